sync_debounce_edge: RTL and testbench

//   Per-bit debounce filter and edge detector sitting directly downstream of the

---
 rtl/sync_debounce_edge.sv | 67 ++++++
 tb/tb_sync_debounce_edge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce_edge.sv
// Per-bit debounce filter with registered rise/fall pulses.
// Sits directly after the synchronizer flop chain in the destination clock domain.
module sync_debounce_edge #(
  parameter int unsigned              DATA_WIDTH    = 4,
  parameter int unsigned              STABLE_CYCLES = 8,
  parameter logic [DATA_WIDTH-1:0]    RESET_LEVEL   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] level,
  output logic [DATA_WIDTH-1:0] rise,
  output logic [DATA_WIDTH-1:0] fall,
  output logic                  changed
);

  localparam int unsigned     CntW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  logic [DATA_WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]           level_q, level_d;
  logic [DATA_WIDTH-1:0]           rise_q, rise_d;
  logic [DATA_WIDTH-1:0]           fall_q, fall_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    if (en) begin
      for (int i = 0; i < int'(DATA_WIDTH); i++) begin
        if (in[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          // Enough consecutive differing samples: accept and pulse on the same edge.
          level_d[i] = in[i];
          cnt_d[i]   = '0;
          rise_d[i]  = in[i];
          fall_d[i]  = ~in[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level   = level_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = |(rise_q | fall_q);

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed bench for sync_debounce_edge: default 4-bit/8-cycle instance plus a
// 1-bit/1-cycle instance for the degenerate pass-through case.
module tb_sync_debounce_edge;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] din, level, rise, fall;
  logic       changed;
  logic [0:0] din1, level1, rise1, fall1;
  logic       changed1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_debounce_edge dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (din),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  sync_debounce_edge #(
    .DATA_WIDTH    (1),
    .STABLE_CYCLES (1),
    .RESET_LEVEL   (1'b0)
  ) dut1 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (din1),
    .level   (level1),
    .rise    (rise1),
    .fall    (fall1),
    .changed (changed1)
  );

  // One sampling edge; outputs are read 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] hold_in);
    rst = 1'b1;
    din = hold_in;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_lvl, exp_rise;
    rst = 1'b1; en = 1'b1; din = 4'hF; din1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (level !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || changed !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: level=%h rise=%h fall=%h changed=%b, required 0 0 0 0",
                 level, rise, fall, changed);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_lvl  = (i >= 8) ? 4'hF : 4'h0;
      exp_rise = (i == 8) ? 4'hF : 4'h0;
      n_chk++;
      if (level !== exp_lvl || rise !== exp_rise || fall !== 4'h0
          || changed !== (i == 8)) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: level=%h rise=%h fall=%h, required %h %h 0",
                 i, level, rise, fall, exp_lvl, exp_rise);
      end
    end
  endtask

  task automatic test_clean_step();
    do_reset(4'h0);
    din = 4'b0001;
    for (int i = 1; i <= 9; i++) begin
      tick();
      n_chk++;
      if (level !== ((i >= 8) ? 4'h1 : 4'h0) || rise !== ((i == 8) ? 4'h1 : 4'h0)
          || changed !== (i == 8)) begin
        n_fail++;
        $display("FAIL step_rise edge %0d: level=%h rise=%h changed=%b", i, level, rise, changed);
      end
    end
    din = 4'b0000;
    for (int i = 1; i <= 9; i++) begin
      tick();
      n_chk++;
      if (level !== ((i >= 8) ? 4'h0 : 4'h1) || fall !== ((i == 8) ? 4'h1 : 4'h0)
          || rise !== 4'h0 || changed !== (i == 8)) begin
        n_fail++;
        $display("FAIL step_fall edge %0d: level=%h fall=%h rise=%h", i, level, fall, rise);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset(4'h0);
    din = 4'b0010;
    for (int i = 0; i < 7; i++) tick();
    din = 4'b0000;
    tick();
    n_chk++;
    if (level !== 4'h0 || rise !== 4'h0 || changed !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_7: level=%h rise=%h, required 0 0", level, rise);
    end
    din = 4'b0010;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_chk++;
      if (level !== ((i == 8) ? 4'h2 : 4'h0) || rise !== ((i == 8) ? 4'h2 : 4'h0)) begin
        n_fail++;
        $display("FAIL glitch_restart edge %0d: level=%h rise=%h", i, level, rise);
      end
    end
  endtask

  task automatic test_enable_freeze();
    do_reset(4'h0);
    din = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (level !== 4'h0 || rise !== 4'h0 || changed !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze cycle %0d: level=%h rise=%h, required 0 0", i, level, rise);
      end
    end
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_chk++;
      if (level !== ((i == 3) ? 4'h1 : 4'h0) || rise !== ((i == 3) ? 4'h1 : 4'h0)) begin
        n_fail++;
        $display("FAIL resume edge %0d: level=%h rise=%h", i, level, rise);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset(4'h0);
    din = 4'b0100;
    for (int i = 0; i < 8; i++) tick();
    n_chk++;
    if (level !== 4'b0100) begin
      n_fail++;
      $display("FAIL simul_setup: level=%h, required 4", level);
    end
    din = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_chk++;
      if (rise !== ((i == 8) ? 4'b0001 : 4'h0) || fall !== ((i == 8) ? 4'b0100 : 4'h0)
          || level !== ((i == 8) ? 4'b0001 : 4'b0100)) begin
        n_fail++;
        $display("FAIL simul edge %0d: level=%h rise=%h fall=%h", i, level, rise, fall);
      end
    end
    din = 4'b1001;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (level !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
      n_fail++;
      $display("FAIL midcount_reset: level=%h rise=%h fall=%h, required 0", level, rise, fall);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_chk++;
      if (level !== ((i == 8) ? 4'b1001 : 4'h0) || rise !== ((i == 8) ? 4'b1001 : 4'h0)) begin
        n_fail++;
        $display("FAIL post_reset edge %0d: level=%h rise=%h", i, level, rise);
      end
    end
  endtask

  task automatic test_pass_through();
    logic v;
    do_reset(4'h0);
    din1 = 1'b0;
    tick();
    v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v    = ~v;
      din1 = v;
      tick();
      n_chk++;
      if (level1 !== v || rise1 !== v || fall1 !== ~v || changed1 !== 1'b1) begin
        n_fail++;
        $display("FAIL toggle %0d: level=%b rise=%b fall=%b changed=%b, required %b %b %b 1",
                 i, level1, rise1, fall1, changed1, v, v, ~v);
      end
    end
    tick();
    n_chk++;
    if (changed1 !== 1'b0 || level1 !== v) begin
      n_fail++;
      $display("FAIL toggle_stop: level=%b changed=%b, required %b 0", level1, changed1, v);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; din = 4'h0; din1 = 1'b0;
    test_reset();
    test_clean_step();
    test_glitch();
    test_enable_freeze();
    test_simultaneous();
    test_pass_through();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
